// File: rtl/nibble_shift_reader_if.sv
// Load/unload handshake bundle for nibble_shift_reader.
// master: word producer plus nibble consumer; slave: the reader itself.
interface nibble_shift_reader_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
);
  logic                   load_valid;
  logic                   load_ready;
  logic [WIDTH*DEPTH-1:0] load_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_last;

  modport master (
    output load_valid,
    output load_data,
    output out_ready,
    input  load_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  out_ready,
    output load_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/nibble_shift_reader.sv
// Parallel-in / serial-out unloader: one DEPTH-nibble word per load, emitted lowest slice first.
// Optional even-parity output out_parity when NIBBLE_PARITY_EN is defined.
module nibble_shift_reader #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_shift_reader_if.slave   bus,
`ifdef NIBBLE_PARITY_EN
  output logic                   out_parity,
`endif
  output logic                   busy
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [WIDTH*DEPTH-1:0] shreg_q, shreg_d;
  logic [IdxW-1:0]        index_q, index_d;

  logic             at_last;
  logic             out_hs;
  logic             load_acc;
  logic [WIDTH-1:0] slice;

  always_comb begin
    slice = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (index_q == IdxW'(k)) begin
        slice = shreg_q[k*WIDTH +: WIDTH];
      end
    end
  end

  assign busy          = (state_q == StShift);
  assign at_last       = (index_q == LastIdx);
  assign bus.out_valid = busy;
  assign bus.out_data  = busy ? slice : '0;
  assign bus.out_last  = busy & at_last;
  assign out_hs        = bus.out_valid & bus.out_ready;
  // Accepting on the last handshake gives zero-bubble back-to-back words.
  assign bus.load_ready = ~rst & ((state_q == StIdle) | (out_hs & at_last));
  assign load_acc      = bus.load_valid & bus.load_ready;

`ifdef NIBBLE_PARITY_EN
  assign out_parity = ^bus.out_data;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    index_d = index_q;
    if (load_acc) begin
      state_d = StShift;
      shreg_d = bus.load_data;
      index_d = '0;
    end else if (out_hs) begin
      if (at_last) begin
        state_d = StIdle;
        index_d = '0;
      end else begin
        index_d = index_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      index_q <= index_d;
    end
  end

endmodule

// File: tb/tb_nibble_shift_reader.sv
// Directed bench for nibble_shift_reader (WIDTH=4, DEPTH=2).
module tb_nibble_shift_reader;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef NIBBLE_PARITY_EN
  logic out_parity;
`endif

  int total = 0;
  int bad   = 0;

  nibble_shift_reader_if #(.WIDTH(4), .DEPTH(2)) bus ();

  nibble_shift_reader #(.WIDTH(4), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
`ifdef NIBBLE_PARITY_EN
    .out_parity (out_parity),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compact check of the out side: valid, data, last.
  task automatic check_out(input string tag, input logic v, input logic [3:0] d, input logic l);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    check({tag, "_data"},  {28'd0, bus.out_data},  {28'd0, d});
    check({tag, "_last"},  {31'd0, bus.out_last},  {31'd0, l});
  endtask

  initial begin
    // Reset with a pending load: nothing may be accepted.
    rst            = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    check("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_out("rst", 1'b0, 4'h0, 1'b0);

    // Plain word A5, consumer always ready.
    rst            = 1'b0;
    bus.load_data  = 8'hA5;
    bus.out_ready  = 1'b1;
    #1;
    check("idle_load_ready", {31'd0, bus.load_ready}, 32'd1);
    tick();
    bus.load_valid = 1'b0;
    #1;
    check_out("a5_n0", 1'b1, 4'h5, 1'b0);
    check("a5_busy", {31'd0, busy}, 32'd1);
    check("a5_n0_load_ready", {31'd0, bus.load_ready}, 32'd0);
    tick();
    check_out("a5_n1", 1'b1, 4'hA, 1'b1);
    check("a5_n1_load_ready", {31'd0, bus.load_ready}, 32'd1);
    tick();
    check_out("a5_done", 1'b0, 4'h0, 1'b0);
    check("a5_done_busy", {31'd0, busy}, 32'd0);

    // Word 3C with a 3-cycle stall; a load attempted mid-word must be ignored.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h3C;
    bus.out_ready  = 1'b0;
    tick();
    bus.load_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_out("stall", 1'b1, 4'hC, 1'b0);
      check("stall_load_ready", {31'd0, bus.load_ready}, 32'd0);
      tick();
    end
    bus.load_valid = 1'b0;
    check_out("stall_hold", 1'b1, 4'hC, 1'b0);
    bus.out_ready  = 1'b1;
    tick();
    check_out("3c_n1", 1'b1, 4'h3, 1'b1);
    tick();
    check_out("3c_done", 1'b0, 4'h0, 1'b0);

    // Back-to-back: 21 then 87 loaded on the last handshake of 21.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h21;
    tick();
    bus.load_valid = 1'b0;
    #1;
    check_out("21_n0", 1'b1, 4'h1, 1'b0);
    tick();
    check_out("21_n1", 1'b1, 4'h2, 1'b1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h87;
    #1;
    check("b2b_load_ready", {31'd0, bus.load_ready}, 32'd1);
    tick();
    bus.load_valid = 1'b0;
    #1;
    check_out("87_n0", 1'b1, 4'h7, 1'b0);
    tick();
    check_out("87_n1", 1'b1, 4'h8, 1'b1);
    tick();
    check_out("87_done", 1'b0, 4'h0, 1'b0);

    // Reset mid-word of F0 discards the remaining nibble.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hF0;
    tick();
    bus.load_valid = 1'b0;
    #1;
    check_out("f0_n0", 1'b1, 4'h0, 1'b0);
    tick();
    check_out("f0_n1", 1'b1, 4'hF, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_load_ready", {31'd0, bus.load_ready}, 32'd0);
    tick();
    rst = 1'b0;
    check_out("midrst", 1'b0, 4'h0, 1'b0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h12;
    tick();
    bus.load_valid = 1'b0;
    #1;
    check_out("12_n0", 1'b1, 4'h2, 1'b0);
    tick();
    check_out("12_n1", 1'b1, 4'h1, 1'b1);
    tick();
    check_out("12_done", 1'b0, 4'h0, 1'b0);

`ifdef NIBBLE_PARITY_EN
    check("par_idle", {31'd0, out_parity}, 32'd0);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h7E;
    tick();
    bus.load_data  = 8'h30;
    bus.load_valid = 1'b0;
    #1;
    check("par_e", {31'd0, out_parity}, 32'd1);
    tick();
    check("par_7", {31'd0, out_parity}, 32'd1);
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    #1;
    check("par_0", {31'd0, out_parity}, 32'd0);
    check("par_0_data", {28'd0, bus.out_data}, 32'h0);
    tick();
    check("par_3", {31'd0, out_parity}, 32'd0);
    check("par_3_data", {28'd0, bus.out_data}, 32'h3);
    tick();
    check("par_done", {31'd0, out_parity}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
